rr_decode_arbiter: RTL

//  Round-robin arbiter and sequencer for the 3-to-8 enable-gated select decoder.

---
 rtl/rr_decode_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter/sequencer driving an 8-way active-low select decoder.
// One owner at a time, a mandatory all-high GAP cycle between owners,
// and an optional hold timeout bounding each ownership.
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] grant_n,
  output logic [2:0] sel,
  output logic       sel_vld,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  // Hold counter value on the last permitted grant cycle.
  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_e            state_q;
  logic [2:0]        ptr_q;
  logic [HOLD_W-1:0] hold_q;
  logic [7:0]        grant_n_q;
  logic [2:0]        sel_q;
  logic              sel_vld_q;
  logic              timeout_q;

  logic [2:0]        win;
  logic              hit_limit;
  logic              end_grant;

  assign grant_n = grant_n_q;
  assign sel     = sel_q;
  assign sel_vld = sel_vld_q;
  assign timeout = timeout_q;

  // First requester at or after ptr, wrapping 7 -> 0.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign hit_limit = (MAX_HOLD != 0) && (hold_q == LIMIT);
  assign end_grant = rel | ~req[sel_q] | hit_limit;

  // Arbitration FSM with registered decoder outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      grant_n_q <= 8'hFF;
      sel_q     <= '0;
      sel_vld_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (|req) begin
            state_q   <= GRANT;
            sel_q     <= win;
            grant_n_q <= ~(8'h01 << win);
            sel_vld_q <= 1'b1;
            hold_q    <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (end_grant) begin
            state_q   <= GAP;
            grant_n_q <= 8'hFF;
            sel_vld_q <= 1'b0;
            ptr_q     <= sel_q + 3'd1;
            // Only a pure limit hit counts as a timeout; rel or a drop wins.
            timeout_q <= hit_limit & ~rel & req[sel_q];
          end else if (hold_q != '1) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
